le_buff_ctrl: RTL and testbench
===============================

# le_buff_ctrl

Sequencer for a Link Element ring buffer (`Buff`).
- Drives the buffer's write/read enables and charge/release/send-ID controls from high-level charge and release requests.
- Uses the buffer's occupancy and the downstream Nack as feedback.
- Sits between the Link Element configuration logic and one `Buff` instance. It turns "hold tokens here, then replay them" into the cycle-level control pattern the buffer requires.

## Interface
Parameters:
- DEPTH_FIFO, 16: depth of the controlled buffer.
- WIDTH_NUM, $clog2(DEPTH_FIFO): occupancy width minus one.
- CHG_LEVEL, 8: occupancy at which charging stops. Legal range 1..DEPTH_FIFO-3.
- TIMEOUT, 255: HOLD watchdog limit in cycles. Used only with the macro.
- WIDTH_TO, 8: watchdog counter width.

Ports (clock and reset first):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- I_Charge  in  1  request to start charging; level.
- I_Release  in  1  request to replay the buffered tokens; level.
- I_Valid  in  1  upstream forward-token valid (FTk.v).
- I_Nack  in  1  downstream Nack (BTk.n).
- I_SendID  in  1  upstream send-ID request.
- I_Num  in  WIDTH_NUM+1  buffer occupancy (O_Num).
- I_Empty  in  1  buffer empty.
- I_Full  in  1  buffer full flag (O_Full).
- O_We, O_Re  out  1 each  buffer write/read enable.
- O_Chg_Buff, O_Rls_Buff  out  1 each  buffer charge/release.
- O_SendID  out  1  gated send-ID to the buffer.
- O_Busy  out  1  high whenever the state is not IDLE.
- O_State  out  3  encoded state.
- O_ChgCnt  out  WIDTH_NUM+1  valid tokens accepted during the last/current charge.
- O_Timeout  out  1  one-cycle watchdog pulse.

## Operation
- Moore FSM. Encoding: IDLE=0, CHARGE=1, HOLD=2, RELEASE=3, DRAIN=4. Outputs decode from the registered state, except O_SendID.
- IDLE (pass-through): We=1, Re=1, Chg=0, Rls=0.
  - I_Charge -> CHARGE; O_ChgCnt clears to 0 on this transition.
  - I_Release alone is ignored.
  - If I_Charge and I_Release are both high, Charge wins.
- CHARGE: We=1, Re=0, Chg=1, Rls=0.
  - O_ChgCnt increments on each I_Valid cycle and saturates at DEPTH_FIFO.
  - I_Release -> RELEASE. This has priority.
  - Otherwise, (I_Num >= CHG_LEVEL) or I_Full -> HOLD.
- HOLD: We=0, Re=0, Chg=1, Rls=0.
  - I_Release -> RELEASE.
  - I_Charge is ignored.
- RELEASE: We=1, Re=1, Chg=1, Rls=1.
  - I_Empty & ~I_Valid -> DRAIN.
- DRAIN: We=1, Re=1, Chg=0, Rls=0.
  - Leaves to IDLE after I_Nack has been low for 2 consecutive cycles. This matches the buffer's 2-deep Nack history, so no pulse-Nack artefact crosses the mode change.
  - The low-run counter restarts whenever I_Nack is high.
- O_SendID:
  - Equals I_SendID combinationally in IDLE.
  - In any other state it is forced to 0, and any I_SendID assertion sets a pending flag.
  - The pending flag drives O_SendID=1 for exactly one cycle, the first IDLE cycle, then clears.
- I_Num is unsigned. Comparisons use WIDTH_NUM+1 bits, with no sign extension.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE; O_ChgCnt=0; the SendID pending flag clears; the watchdog clears.
  - Outputs during and after reset: O_We=1, O_Re=1, O_Chg_Buff=0, O_Rls_Buff=0, O_SendID=I_SendID, O_Busy=0, O_State=0, O_Timeout=0.
- Reset mid-operation (e.g. in HOLD) abandons the charge. The buffer contents are not flushed by this block.
- Latency:
  - Request to control change: 1 cycle. A request sampled at edge N changes the outputs after edge N.
  - CHARGE->HOLD: 1 cycle after the occupancy condition is seen.
- Release sequence length: minimum RELEASE 1 cycle + DRAIN 2 cycles = 3 cycles after a release request from HOLD with an empty buffer.

## Configuration
- LE_BUFF_CTRL_TIMEOUT_EN defined:
  - A WIDTH_TO-bit counter runs in HOLD. It clears on entry to HOLD.
  - When it reaches TIMEOUT, O_Timeout pulses for 1 cycle and the state is forced to RELEASE, as if I_Release were high.
- Not defined: no counter is built, HOLD waits indefinitely, and O_Timeout is tied to 0.

## Test plan
- Reset asserted mid-CHARGE -> same cycle O_State=0, O_We=1, O_Re=1, O_Chg_Buff=0, O_ChgCnt=0.
- I_Charge pulse, 8 valid tokens, I_Num ramping 0..8 (CHG_LEVEL=8) -> CHARGE for 8 cycles, then HOLD with O_ChgCnt=8, We=Re=0, Chg=1.
- In HOLD, I_Release; buffer drains 8->0; I_Nack low -> RELEASE (Chg=Rls=1) until I_Empty, then DRAIN 2 cycles, then IDLE.
- In DRAIN, I_Nack pattern 0,1,0,0 -> IDLE is reached only after the final two lows, i.e. 4 cycles in DRAIN.
- I_SendID pulsed during HOLD -> O_SendID=0 in HOLD, then exactly one O_SendID=1 cycle on the first IDLE cycle.
- With LE_BUFF_CTRL_TIMEOUT_EN and TIMEOUT=10, hold with no release -> O_Timeout pulses 10 cycles after HOLD entry and the state becomes RELEASE. Without the macro, the state stays HOLD indefinitely.

Source files
------------

// File: rtl/le_buff_ctrl.sv
// le_buff_ctrl: sequences one Link Element ring buffer through charge, hold, release and drain.
// Latency: 1 cycle from a request to the control change. No backpressure; it follows I_Num, I_Empty and I_Nack.
// Build option: define LE_BUFF_CTRL_TIMEOUT_EN to add the HOLD watchdog. Without it, HOLD waits indefinitely.
module le_buff_ctrl #(
    parameter int DEPTH_FIFO = 16,
    parameter int WIDTH_NUM  = $clog2(DEPTH_FIFO),
    parameter int CHG_LEVEL  = 8,
    parameter int TIMEOUT    = 255,
    parameter int WIDTH_TO   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Charge,
    input  logic                 I_Release,
    input  logic                 I_Valid,
    input  logic                 I_Nack,
    input  logic                 I_SendID,
    input  logic [WIDTH_NUM:0]   I_Num,
    input  logic                 I_Empty,
    input  logic                 I_Full,
    output logic                 O_We,
    output logic                 O_Re,
    output logic                 O_Chg_Buff,
    output logic                 O_Rls_Buff,
    output logic                 O_SendID,
    output logic                 O_Busy,
    output logic [2:0]           O_State,
    output logic [WIDTH_NUM:0]   O_ChgCnt,
    output logic                 O_Timeout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHARGE  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [WIDTH_NUM:0] CHG_LVL = (WIDTH_NUM+1)'(CHG_LEVEL);
    localparam logic [WIDTH_NUM:0] CNT_MAX = (WIDTH_NUM+1)'(DEPTH_FIFO);

    state_t             state, state_nxt;
    logic [WIDTH_NUM:0] chg_cnt;
    logic               sid_pend;
    logic               nack_low;
    logic               to_hit;

`ifdef LE_BUFF_CTRL_TIMEOUT_EN
    localparam logic [WIDTH_TO-1:0] TO_LIM = WIDTH_TO'(TIMEOUT);
    logic [WIDTH_TO-1:0] wd_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (state != ST_HOLD)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + WIDTH_TO'(1);
    end

    assign to_hit = (state == ST_HOLD) && (wd_cnt == TO_LIM);
`else
    logic unused_to_cfg;
    assign unused_to_cfg = (TIMEOUT == WIDTH_TO);
    assign to_hit        = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        O_We       = 1'b1;
        O_Re       = 1'b1;
        O_Chg_Buff = 1'b0;
        O_Rls_Buff = 1'b0;
        case (state)
            ST_IDLE: begin
                if (I_Charge)
                    state_nxt = ST_CHARGE;
            end
            ST_CHARGE: begin
                O_Re       = 1'b0;
                O_Chg_Buff = 1'b1;
                if (I_Release)
                    state_nxt = ST_RELEASE;
                else if ((I_Num >= CHG_LVL) || I_Full)
                    state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                O_We       = 1'b0;
                O_Re       = 1'b0;
                O_Chg_Buff = 1'b1;
                if (I_Release || to_hit)
                    state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                O_Chg_Buff = 1'b1;
                O_Rls_Buff = 1'b1;
                if (I_Empty && !I_Valid)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Two consecutive Nack-low cycles flush the buffer's Nack history.
                if (!I_Nack && nack_low)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chg_cnt  <= '0;
            sid_pend <= 1'b0;
            nack_low <= 1'b0;
        end else begin
            if (state == ST_IDLE && state_nxt == ST_CHARGE)
                chg_cnt <= '0;
            else if (state == ST_CHARGE && I_Valid && chg_cnt != CNT_MAX)
                chg_cnt <= chg_cnt + (WIDTH_NUM+1)'(1);

            if (state == ST_IDLE)
                sid_pend <= 1'b0;
            else if (I_SendID)
                sid_pend <= 1'b1;

            nack_low <= (state == ST_DRAIN) && !I_Nack;
        end
    end

    assign O_SendID  = (state == ST_IDLE) ? (I_SendID | sid_pend) : 1'b0;
    assign O_Busy    = (state != ST_IDLE);
    assign O_State   = state;
    assign O_ChgCnt  = chg_cnt;
    assign O_Timeout = to_hit;

endmodule

// File: tb/tb_le_buff_ctrl.sv
// Scoreboard bench for le_buff_ctrl: each directed cycle queues its hand-computed outputs and a negedge monitor compares them.
module tb_le_buff_ctrl;

    localparam int NW = 5;

    logic          clock;
    logic          reset;
    logic          I_Charge, I_Release, I_Valid, I_Nack, I_SendID, I_Empty, I_Full;
    logic [NW-1:0] I_Num;
    logic          O_We, O_Re, O_Chg_Buff, O_Rls_Buff, O_SendID, O_Busy, O_Timeout;
    logic [2:0]    O_State;
    logic [NW-1:0] O_ChgCnt;

    typedef struct {
        int            cyc;
        logic [2:0]    st;
        logic          sid;
        logic [NW-1:0] cnt;
        logic          to;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    le_buff_ctrl #(
        .DEPTH_FIFO(16), .WIDTH_NUM(4), .CHG_LEVEL(8), .TIMEOUT(10), .WIDTH_TO(8)
    ) dut (
        .clock(clock), .reset(reset),
        .I_Charge(I_Charge), .I_Release(I_Release), .I_Valid(I_Valid), .I_Nack(I_Nack),
        .I_SendID(I_SendID), .I_Num(I_Num), .I_Empty(I_Empty), .I_Full(I_Full),
        .O_We(O_We), .O_Re(O_Re), .O_Chg_Buff(O_Chg_Buff), .O_Rls_Buff(O_Rls_Buff),
        .O_SendID(O_SendID), .O_Busy(O_Busy), .O_State(O_State), .O_ChgCnt(O_ChgCnt),
        .O_Timeout(O_Timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Buffer control pattern per state: {We, Re, Chg, Rls}
    function automatic logic [3:0] ctl_of(input logic [2:0] st);
        case (st)
            3'd0:    return 4'b1100;
            3'd1:    return 4'b1010;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b1111;
            default: return 4'b1100;
        endcase
    endfunction

    task automatic step(input logic rst_v, ch, rl, v, n, sid, input logic [NW-1:0] num,
                        input logic emp, full, input logic [2:0] es, input logic esid,
                        input logic [NW-1:0] ecnt, input logic eto);
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        reset = rst_v; I_Charge = ch; I_Release = rl; I_Valid = v; I_Nack = n;
        I_SendID = sid; I_Num = num; I_Empty = emp; I_Full = full;
        e.cyc = cyc; e.st = es; e.sid = esid; e.cnt = ecnt; e.to = eto;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [14:0] act, req;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {O_State, O_We, O_Re, O_Chg_Buff, O_Rls_Buff, O_SendID, O_Busy, O_ChgCnt, O_Timeout};
                req = {e.st, ctl_of(e.st), e.sid, (e.st != 3'd0), e.cnt, e.to};
                n_chk++;
                if (act !== req) begin
                    n_fail++;
                    $display("FAIL cycle%0d outputs {st,we,re,chg,rls,sid,busy,cnt,to}: got %b required %b",
                             e.cyc, act, req);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL sim_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; I_Charge = 0; I_Release = 0; I_Valid = 0; I_Nack = 0;
        I_SendID = 0; I_Num = '0; I_Empty = 1; I_Full = 0;

        // rst ch rl v n sid num emp full | st sid cnt to
        step(1, 0, 0, 0, 0, 1, 0, 1, 0,   0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0, 0,   1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 2, 0, 0,   1, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0, 3, 0, 0,   0, 0, 0, 0);

        step(0, 1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            step(0, 0, 0, 1, 0, 0, NW'(k + 1), 0, 0, 1, 0, NW'(k), 0);
        step(0, 1, 0, 0, 0, 1, 8, 0, 0,   2, 0, 8, 0);
`ifdef LE_BUFF_CTRL_TIMEOUT_EN
        for (int k = 1; k <= 10; k++)
            step(0, 0, 0, 0, 0, 0, 8, 0, 0, 2, 0, 8, (k == 10));
`else
        for (int k = 1; k <= 20; k++)
            step(0, 0, 0, 0, 0, 0, 8, 0, 0, 2, 0, 8, 0);
        step(0, 0, 1, 0, 0, 0, 8, 0, 0,   2, 0, 8, 0);
`endif
        for (int k = 0; k < 8; k++)
            step(0, 0, 0, 0, 0, 0, NW'(8 - k), 0, 0, 3, 0, 8, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1, 0,   3, 0, 8, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   3, 0, 8, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   4, 0, 8, 0);
        step(0, 0, 0, 0, 1, 0, 0, 1, 0,   4, 0, 8, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   4, 0, 8, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   4, 0, 8, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 8, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 8, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0,   0, 1, 8, 0);

        step(0, 1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 8, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 1,   1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   3, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   4, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   4, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0);

        step(0, 1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0);
        for (int k = 0; k < 18; k++)
            step(0, 0, 0, 1, 0, 0, 7, 0, 0, 1, 0, NW'((k > 16) ? 16 : k), 0);
        step(0, 0, 0, 0, 0, 0, 7, 0, 1,   1, 0, 16, 0);
        step(0, 1, 0, 0, 0, 0, 7, 0, 1,   2, 0, 16, 0);
        step(1, 0, 0, 0, 0, 0, 7, 0, 1,   0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);

        @(negedge clock);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
